// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : watch_pkg
// Description : Shared state codes, field codes, button-select type and
//               default timing for the watch edit controller.
//               Optional macro: WATCH_EDIT_SECONDS_EN (adds seconds field).
// Revision    : 1.0 - initial release
// ============================================================================
package watch_pkg;

    localparam logic [2:0] c_ST_RUN    = 3'd0;
    localparam logic [2:0] c_ST_IDLE   = 3'd1;
    localparam logic [2:0] c_ST_PRESS  = 3'd2;
    localparam logic [2:0] c_ST_HOLD   = 3'd3;
    localparam logic [2:0] c_ST_REPEAT = 3'd4;

    localparam logic [1:0] FIELD_MIN = 2'd0;
    localparam logic [1:0] FIELD_HR  = 2'd1;
    localparam logic [1:0] FIELD_SEC = 2'd2;

    localparam int c_DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int c_DEF_HOLD_CYCLES     = 50_000_000;
    localparam int c_DEF_REPEAT_CYCLES   = 25_000_000;
    localparam int c_DEF_CNT_W           = 32;

    typedef enum logic [1:0] {
        BTN_NONE  = 2'd0,
        BTN_SHIFT = 2'd1,
        BTN_INC   = 2'd2,
        BTN_DEC   = 2'd3
    } btn_sel_e;

    function automatic logic [1:0] next_field(input logic [1:0] cur);
        logic [1:0] nxt;
`ifdef WATCH_EDIT_SECONDS_EN
        case (cur)
            FIELD_HR:  nxt = FIELD_MIN;
            FIELD_MIN: nxt = FIELD_SEC;
            default:   nxt = FIELD_HR;
        endcase
`else
        nxt = (cur == FIELD_HR) ? FIELD_MIN : FIELD_HR;
`endif
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : 2-FF synchronizer followed by a stability counter; the output
//               level flips only after DEBOUNCE_CYCLES consecutive differing
//               samples.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_sync;

    assign w_sync  = r_sync[1];
    assign o_level = r_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (w_sync != r_level) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_level <= w_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end else begin
                // any agreeing sample restarts the stability window
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/watch_edit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : watch_edit_ctrl
// Description : Button edit controller for the 24 h clock: debounces the
//               buttons and issues inc/dec/shift commands with auto-repeat.
//               Optional macro: WATCH_EDIT_SECONDS_EN (seconds field editable,
//               no seconds clear on edit exit).
// Revision    : 1.0 - initial release
// ============================================================================
module watch_edit_ctrl
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = c_DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = c_DEF_REPEAT_CYCLES,
    parameter int CNT_W           = c_DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_edit,
    input  logic       btn_shift,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic       edit_mode,
    output logic [1:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       shift_conf,
    output logic       clr_sec
);

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [3:0]       w_raw;
    logic [3:0]       w_db;
    logic             w_edit;
    logic             w_shift;
    logic             w_inc;
    logic             w_dec;

    logic [2:0]       r_state;
    btn_sel_e         r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_field;

    logic             w_held;
    btn_sel_e         w_pick;
    logic             w_exit;
    logic             w_hold_fire;
    logic             w_rep_fire;
    logic             w_cmd;

    assign w_raw = {btn_dec, btn_inc, btn_shift, btn_edit};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_db
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .reset  (reset),
                .i_raw  (w_raw[gi]),
                .o_level(w_db[gi])
            );
        end
    endgenerate

    assign w_edit  = w_db[0];
    assign w_shift = w_db[1];
    assign w_inc   = w_db[2];
    assign w_dec   = w_db[3];

    always_comb begin
        w_held = 1'b0;
        case (r_sel)
            BTN_SHIFT: w_held = w_shift;
            BTN_INC:   w_held = w_inc;
            BTN_DEC:   w_held = w_dec;
            default:   w_held = 1'b0;
        endcase
    end

    // inc and dec together without shift are ambiguous and are ignored
    always_comb begin
        w_pick = BTN_NONE;
        if (w_shift) begin
            w_pick = BTN_SHIFT;
        end else if (w_inc && !w_dec) begin
            w_pick = BTN_INC;
        end else if (w_dec && !w_inc) begin
            w_pick = BTN_DEC;
        end
    end

    assign w_exit      = (r_state != c_ST_RUN) && !w_edit;
    assign w_hold_fire = (r_state == c_ST_HOLD) && w_held &&
                         (r_sel != BTN_SHIFT) && (r_cnt == c_HOLD_LAST);
    assign w_rep_fire  = (r_state == c_ST_REPEAT) && w_held && (r_cnt == c_REP_LAST);
    assign w_cmd       = w_edit && ((r_state == c_ST_PRESS) || w_hold_fire || w_rep_fire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_RUN;
            r_sel   <= BTN_NONE;
            r_cnt   <= '0;
            r_field <= FIELD_HR;
        end else if (w_exit) begin
            // leaving edit cancels any press in flight; field is kept
            r_state <= c_ST_RUN;
            r_sel   <= BTN_NONE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    r_cnt <= '0;
                    if (w_edit) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_pick != BTN_NONE) begin
                        r_sel   <= w_pick;
                        r_state <= c_ST_PRESS;
                    end
                end
                c_ST_PRESS: begin
                    if (r_sel == BTN_SHIFT) begin
                        r_field <= next_field(r_field);
                    end
                    r_cnt   <= '0;
                    r_state <= c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    if (!w_held) begin
                        r_state <= c_ST_IDLE;
                        r_sel   <= BTN_NONE;
                        r_cnt   <= '0;
                    end else if (w_hold_fire) begin
                        r_state <= c_ST_REPEAT;
                        r_cnt   <= '0;
                    end else if (r_sel != BTN_SHIFT) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_REPEAT: begin
                    if (!w_held) begin
                        r_state <= c_ST_IDLE;
                        r_sel   <= BTN_NONE;
                        r_cnt   <= '0;
                    end else if (w_rep_fire) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_sel   <= BTN_NONE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign edit_mode  = w_edit;
    assign field_sel  = r_field;
    assign inc_pulse  = w_cmd && (r_sel == BTN_INC);
    assign dec_pulse  = w_cmd && (r_sel == BTN_DEC);
    assign shift_conf = w_edit && (r_sel == BTN_SHIFT) &&
                        ((r_state == c_ST_PRESS) || ((r_state == c_ST_HOLD) && w_held));

`ifdef WATCH_EDIT_SECONDS_EN
    assign clr_sec = 1'b0;
`else
    assign clr_sec = w_exit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_watch_edit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_watch_edit_ctrl
// Description : Self-checking bench for watch_edit_ctrl with a timeline model
//               of button presses. Honours WATCH_EDIT_SECONDS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_watch_edit_ctrl;

    localparam int DB = 4;
    localparam int HC = 20;
    localparam int RC = 10;
    localparam int NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_edit = 1'b0;
    logic       btn_shift = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       edit_mode;
    logic [1:0] field_sel;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       shift_conf;
    logic       clr_sec;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int viol     = 0;
    int exp_field = 1;
    int inc_q[$];
    int dec_q[$];
    int sc_q[$];
    int clr_q[$];
    int exp_q[$];
`ifdef WATCH_EDIT_SECONDS_EN
    int nxt_fld[3] = '{2, 0, 1};
    int exp_clr = 0;
`else
    int nxt_fld[3] = '{1, 0, 1};
    int exp_clr = 1;
`endif

    watch_edit_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC),
        .REPEAT_CYCLES  (RC),
        .CNT_W          (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_edit  (btn_edit),
        .btn_shift (btn_shift),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .edit_mode (edit_mode),
        .field_sel (field_sel),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse),
        .shift_conf(shift_conf),
        .clr_sec   (clr_sec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (inc_pulse)  inc_q.push_back(cyc);
        if (dec_pulse)  dec_q.push_back(cyc);
        if (shift_conf) sc_q.push_back(cyc);
        if (clr_sec)    clr_q.push_back(cyc);
        if (inc_pulse && dec_pulse) viol++;
        if ((inc_pulse || dec_pulse) && !edit_mode) viol++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        inc_q.delete(); dec_q.delete(); sc_q.delete(); clr_q.delete();
    endtask

    // Raw press after edge k, raw release after edge f, edit level lost at cycle lim.
    // Debounced level is high over cycles [k+2+DB, f+1+DB]; first command one cycle later.
    function automatic void model_press(input int k, input int f, input int lim);
        int stop;
        int t;
        exp_q.delete();
        if (f - k < DB) return;
        stop = (f + 2 + DB < lim) ? f + 2 + DB : lim;
        t = k + 3 + DB;
        if (t < stop) exp_q.push_back(t);
        t = t + HC;
        while (t < stop) begin
            exp_q.push_back(t);
            t = t + RC;
        end
    endfunction

    task automatic test_reset();
        int k;
        reset = 1'b0;
        tick(3);
        n_checks++;
        if ({edit_mode, inc_pulse, dec_pulse, shift_conf, clr_sec} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {edit_mode, inc_pulse, dec_pulse, shift_conf, clr_sec});
        end
        n_checks++;
        if (field_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_field: got %0d expected 1", field_sel);
        end
        reset = 1'b1;
        tick(2);
        btn_edit = 1'b1;
        k = cyc;
        tick(DB + 1);
        @(negedge clk);
        n_checks++;
        if (edit_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL edit_early: cycle %0d got %b expected 0", cyc - k, edit_mode);
        end
        @(negedge clk);
        n_checks++;
        if (edit_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL edit_latency: cycle %0d got %b expected 1", cyc - k, edit_mode);
        end
        tick(5);
    endtask

    task automatic test_inc_tap();
        int k, f, d;
        for (int it = 0; it < 3; it++) begin
            clear_q();
            d = (it == 0) ? 8 : $urandom_range(DB, 15);
            btn_inc = 1'b1;
            k = cyc;
            tick(d);
            btn_inc = 1'b0;
            f = cyc;
            tick(20);
            model_press(k, f, NEVER);
            n_checks++;
            if (inc_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL tap_count: d=%0d got %0d expected %0d", d, inc_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_checks++;
                    if (inc_q[i] - k !== exp_q[i] - k) begin
                        n_fail++;
                        $display("FAIL tap_time: got %0d expected %0d", inc_q[i] - k, exp_q[i] - k);
                    end
                end
            end
            n_checks++;
            if (dec_q.size() !== 0) begin
                n_fail++;
                $display("FAIL tap_no_dec: got %0d expected 0", dec_q.size());
            end
        end
    endtask

    task automatic test_dec_hold();
        int k, f, d;
        for (int it = 0; it < 2; it++) begin
            clear_q();
            d = (it == 0) ? 60 : $urandom_range(45, 75);
            btn_dec = 1'b1;
            k = cyc;
            tick(d);
            btn_dec = 1'b0;
            f = cyc;
            tick(25);
            model_press(k, f, NEVER);
            n_checks++;
            if (dec_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL hold_count: d=%0d got %0d expected %0d", d, dec_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_checks++;
                    if (dec_q[i] - k !== exp_q[i] - k) begin
                        n_fail++;
                        $display("FAIL hold_time[%0d]: got %0d expected %0d", i, dec_q[i] - k, exp_q[i] - k);
                    end
                end
            end
            n_checks++;
            if (inc_q.size() !== 0) begin
                n_fail++;
                $display("FAIL hold_no_inc: got %0d expected 0", inc_q.size());
            end
        end
    endtask

    task automatic test_shift();
        int k, f, d;
        clear_q();
        d = $urandom_range(1, DB - 1);
        btn_shift = 1'b1;
        tick(d);
        btn_shift = 1'b0;
        tick(15);
        n_checks++;
        if (field_sel !== 2'(exp_field) || sc_q.size() !== 0) begin
            n_fail++;
            $display("FAIL shift_glitch: field %0d conf %0d expected field %0d conf 0",
                     field_sel, sc_q.size(), exp_field);
        end
        for (int it = 0; it < 2; it++) begin
            clear_q();
            d = (it == 0) ? 30 : $urandom_range(10, 40);
            btn_shift = 1'b1;
            k = cyc;
            tick(d);
            btn_shift = 1'b0;
            f = cyc;
            tick(15);
            exp_field = nxt_fld[exp_field];
            n_checks++;
            if (field_sel !== 2'(exp_field)) begin
                n_fail++;
                $display("FAIL shift_field: got %0d expected %0d", field_sel, exp_field);
            end
            n_checks++;
            if (sc_q.size() !== d - 1) begin
                n_fail++;
                $display("FAIL shift_conf_len: got %0d expected %0d", sc_q.size(), d - 1);
            end else begin
                n_checks++;
                if (sc_q[0] - k !== DB + 3 || sc_q[$] - f !== DB + 1) begin
                    n_fail++;
                    $display("FAIL shift_conf_span: got %0d..%0d expected %0d..%0d",
                             sc_q[0] - k, sc_q[$] - f, DB + 3, DB + 1);
                end
            end
            n_checks++;
            if (inc_q.size() + dec_q.size() !== 0) begin
                n_fail++;
                $display("FAIL shift_no_repeat: got %0d pulses expected 0", inc_q.size() + dec_q.size());
            end
        end
    endtask

    task automatic test_simultaneous();
        int d;
        clear_q();
        d = $urandom_range(20, 40);
        btn_inc = 1'b1; btn_dec = 1'b1;
        tick(d);
        btn_inc = 1'b0; btn_dec = 1'b0;
        tick(15);
        n_checks++;
        if (inc_q.size() + dec_q.size() + sc_q.size() !== 0 || field_sel !== 2'(exp_field)) begin
            n_fail++;
            $display("FAIL both_incdec: got %0d events field %0d expected 0 events field %0d",
                     inc_q.size() + dec_q.size() + sc_q.size(), field_sel, exp_field);
        end
        clear_q();
        d = 30;
        btn_shift = 1'b1; btn_inc = 1'b1; btn_dec = 1'b1;
        tick(d);
        btn_shift = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        tick(15);
        exp_field = nxt_fld[exp_field];
        n_checks++;
        if (field_sel !== 2'(exp_field) || sc_q.size() !== d - 1) begin
            n_fail++;
            $display("FAIL all_three_shift: field %0d conf %0d expected field %0d conf %0d",
                     field_sel, sc_q.size(), exp_field, d - 1);
        end
        n_checks++;
        if (inc_q.size() + dec_q.size() !== 0) begin
            n_fail++;
            $display("FAIL all_three_pulses: got %0d expected 0", inc_q.size() + dec_q.size());
        end
    endtask

    task automatic test_edit_exit();
        int k, e, f;
        clear_q();
        btn_inc = 1'b1;
        k = cyc;
        tick($urandom_range(30, 60));
        btn_edit = 1'b0;
        e = cyc;
        tick(25);
        btn_inc = 1'b0;
        f = cyc;
        tick(15);
        model_press(k, f, e + 2 + DB);
        n_checks++;
        if (inc_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL exit_count: got %0d expected %0d", inc_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (inc_q[i] - k !== exp_q[i] - k) begin
                    n_fail++;
                    $display("FAIL exit_time[%0d]: got %0d expected %0d", i, inc_q[i] - k, exp_q[i] - k);
                end
            end
        end
        n_checks++;
        if (clr_q.size() !== exp_clr) begin
            n_fail++;
            $display("FAIL exit_clr_count: got %0d expected %0d", clr_q.size(), exp_clr);
        end else if (exp_clr == 1) begin
            n_checks++;
            if (clr_q[0] - e !== DB + 2) begin
                n_fail++;
                $display("FAIL exit_clr_time: got %0d expected %0d", clr_q[0] - e, DB + 2);
            end
        end
        n_checks++;
        if (edit_mode !== 1'b0 || field_sel !== 2'(exp_field)) begin
            n_fail++;
            $display("FAIL exit_state: edit %b field %0d expected edit 0 field %0d",
                     edit_mode, field_sel, exp_field);
        end
    endtask

    task automatic test_reset_midop();
        int k;
        btn_edit = 1'b1;
        tick(12);
        for (int it = 0; it < 3 && exp_field == 1; it++) begin
            btn_shift = 1'b1;
            tick(8);
            btn_shift = 1'b0;
            tick(15);
            exp_field = nxt_fld[exp_field];
        end
        n_checks++;
        if (field_sel !== 2'(exp_field)) begin
            n_fail++;
            $display("FAIL midop_pre_field: got %0d expected %0d", field_sel, exp_field);
        end
        clear_q();
        btn_inc = 1'b1;
        k = cyc;
        tick(DB + 3 + HC);
        #1;
        reset = 1'b0;
        #1;
        exp_field = 1;
        n_checks++;
        if ({edit_mode, inc_pulse, dec_pulse, shift_conf, clr_sec} !== 5'b0 || field_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL midop_reset: got %b field %0d expected 00000 field 1",
                     {edit_mode, inc_pulse, dec_pulse, shift_conf, clr_sec}, field_sel);
        end
        btn_inc = 1'b0;
        btn_edit = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(15);
        n_checks++;
        if (inc_q.size() !== 1) begin
            n_fail++;
            $display("FAIL midop_pulses: got %0d expected 1", inc_q.size());
        end else begin
            n_checks++;
            if (inc_q[0] - k !== DB + 3) begin
                n_fail++;
                $display("FAIL midop_first: got %0d expected %0d", inc_q[0] - k, DB + 3);
            end
        end
    endtask

    task automatic test_pulse_rules();
        n_checks++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL pulse_rules: got %0d violations expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_inc_tap();
        test_dec_hold();
        test_shift();
        test_simultaneous();
        test_edit_exit();
        test_reset_midop();
        test_pulse_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/watch_edit_ctrl.md
Name: watch_edit_ctrl

Overview:
- Button-driven edit controller for the 24 h digital clock datapath (hours/minutes/seconds counters).
- Synchronizes and debounces the raw board buttons, then runs the edit-mode state machine.
- Issues single-cycle increment, decrement and field-shift commands to the time counter, with auto-repeat on long press.
- Gates the 1 Hz run tick while editing; the time counter only executes the commands.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized button must be stable before its level is accepted.
- HOLD_CYCLES, 50_000_000: press duration before auto-repeat starts.
- REPEAT_CYCLES, 25_000_000: period between auto-repeat pulses.
- CNT_W, 32: width of the hold/repeat counter; must hold max(HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  system clock (100 MHz on board).
- reset  in  1  asynchronous, active-low reset.
- btn_edit  in  1  raw edit-mode level switch (1 = edit).
- btn_shift  in  1  raw field-shift button.
- btn_inc  in  1  raw increment button.
- btn_dec  in  1  raw decrement button.
- edit_mode  out  1  debounced edit level; counter suppresses run tick when 1.
- field_sel  out  2  selected field: 2'd1 hours, 2'd0 minutes, 2'd2 seconds (feature only).
- inc_pulse  out  1  one-cycle increment command for field_sel.
- dec_pulse  out  1  one-cycle decrement command for field_sel.
- shift_conf  out  1  high while an accepted shift press is held (LED confirm).
- clr_sec  out  1  one-cycle pulse on edit exit; counter zeroes seconds.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0 except field_sel=2'd1 (hours). Synchronizers, debouncers and counters clear; state=RUN.
- Input path per button:
  - 2-FF synchronizer, then debouncer.
  - Debounced level toggles only after DEBOUNCE_CYCLES consecutive cycles with the synced input differing from it.
  - Glitches shorter than that are ignored.
- States: RUN, IDLE, PRESS, HOLD, REPEAT.
- RUN:
  - edit_mode=0.
  - Debounced btn_edit rising moves to IDLE, with edit_mode=1 from the same cycle.
- IDLE:
  - Arbitrate on debounced levels with priority shift > inc > dec.
  - inc and dec high together with no shift: no action, stay in IDLE.
  - On the accepted button go to PRESS.
- PRESS (one cycle):
  - shift: rotate field_sel hours->minutes->hours; set shift_conf=1.
  - inc: assert inc_pulse.
  - dec: assert dec_pulse.
  - Load counter=0; go to HOLD.
- HOLD:
  - Counter increments each cycle while the accepted button stays high.
  - Counter reaches HOLD_CYCLES-1 with inc/dec: go to REPEAT, counter=0, emit one pulse.
  - shift never repeats; it stays in HOLD until release.
- REPEAT: one pulse every REPEAT_CYCLES while held.
- Release (HOLD or REPEAT): accepted button falls -> IDLE next cycle; shift_conf=0; counter=0.
- Other buttons while one is held are ignored, including a later shift.
- Edit exit: debounced btn_edit falls in any edit state:
  - go to RUN;
  - clr_sec=1 for one cycle;
  - any in-flight repeat is cancelled, with no further pulses;
  - field_sel is retained.
- Pulse rule: inc_pulse and dec_pulse are never high together and never high in RUN.
- Latency: from a clean raw edge to the first pulse is 2 (sync) + DEBOUNCE_CYCLES + 1 (PRESS) cycles.
- Reset mid-operation: immediate return to reset values; no pulse emitted.

Optional Feature:
- Macro WATCH_EDIT_SECONDS_EN.
- Defined:
  - shift rotation is hours->minutes->seconds->hours;
  - inc/dec apply to seconds when field_sel=2;
  - clr_sec is not asserted on exit, so the edited seconds are kept.
- Undefined:
  - field_sel never takes 2'd2;
  - clr_sec is pulsed on exit.

Decomposition:
- Shared package watch_pkg:
  - state encoding (RUN, IDLE, PRESS, HOLD, REPEAT);
  - field codes FIELD_MIN=2'd0, FIELD_HR=2'd1, FIELD_SEC=2'd2;
  - default timing constants.
- Sub-module btn_debounce (synchronizer plus stability counter, parameter DEBOUNCE_CYCLES), instantiated four times.

Test Plan (bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=10):
- Reset check: reset low mid-run -> all outputs 0 and field_sel=1 immediately; release and raise btn_edit -> edit_mode=1 exactly 2+4 cycles later.
- Short inc tap: edit mode, btn_inc high 8 cycles -> exactly one inc_pulse, 7 cycles after the raw edge; no dec_pulse.
- Long dec hold: btn_dec high 60 cycles -> first dec_pulse, second 20 cycles later, then every 10 cycles; stops within 6 cycles of release.
- Shift and glitch: btn_shift 3-cycle glitch -> no change. A 30-cycle press -> field_sel 1->0, shift_conf high until release+debounce, no repeat. A second press -> field_sel=1 (=2 with WATCH_EDIT_SECONDS_EN).
- Simultaneous buttons: inc and dec together -> no pulses. shift, inc and dec together -> shift only.
- Edit exit during repeat: btn_inc held in REPEAT, btn_edit falls -> edit_mode=0, one clr_sec pulse (none with WATCH_EDIT_SECONDS_EN), no further inc_pulse.
